// File: rtl/kbd_pkg.sv
// Shared scan-code constants, FSM state type and default key table for the
// keyboard keymap decoder.
package kbd_pkg;

   localparam logic [7:0] ENTER = 8'd13;
   localparam logic [7:0] KEY_Z = 8'd90;
   localparam logic [7:0] KEY_X = 8'd58;
   localparam logic [7:0] LEFT  = 8'd37;
   localparam logic [7:0] RIGHT = 8'd39;
   localparam logic [7:0] BREAK = 8'hF0;

   localparam int DEF_NUM_KEYS = 5;

   // Key i sits at bits [i*8 +: 8], so ENTER is key 0 and RIGHT is key 4.
   localparam logic [DEF_NUM_KEYS*8-1:0] DEF_KEY_CODES = {RIGHT, LEFT, KEY_X, KEY_Z, ENTER};

   typedef enum logic {
      IDLE,
      BRK
   } kbd_state_t;

endpackage

// File: rtl/kbd_code_match.sv
// Combinational compare of a received code against the key table, yielding a
// per-key hit vector and a break-prefix flag.
module kbd_code_match
   import kbd_pkg::*;
#(
   parameter int                         NUM_KEYS   = DEF_NUM_KEYS,
   parameter int                         CODE_W     = 8,
   parameter logic [NUM_KEYS*CODE_W-1:0] KEY_CODES  = DEF_KEY_CODES,
   parameter logic [CODE_W-1:0]          BREAK_CODE = BREAK
) (
   input  logic [CODE_W-1:0]   rx,
   output logic [NUM_KEYS-1:0] hit,
   output logic                is_break
);

   logic [NUM_KEYS-1:0] raw_hit;

   assign is_break = (rx == BREAK_CODE);

   // Duplicate table entries simply raise several hit bits at once.
   always_comb begin
      // NOTE: every bit gets a value on every path, otherwise synthesis infers a latch.
      raw_hit = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         raw_hit[i] = (rx == KEY_CODES[i*CODE_W +: CODE_W]);
      end
   end

   // A table entry equal to the break prefix is never treated as a key.
   assign hit = is_break ? '0 : raw_hit;

endmodule

// File: rtl/kbd_keymap_decoder.sv
// Keyboard scan-code decoder: make/break tracking into held levels, sticky
// press flags with clear-on-consume, unknown-code strobe and auto-repeat.
module kbd_keymap_decoder
   import kbd_pkg::*;
#(
   parameter int                         NUM_KEYS      = DEF_NUM_KEYS,
   parameter int                         CODE_W        = 8,
   parameter logic [NUM_KEYS*CODE_W-1:0] KEY_CODES     = DEF_KEY_CODES,
   parameter logic [CODE_W-1:0]          BREAK_CODE    = BREAK,
   parameter bit                         REPEAT_EN     = 1'b1,
   parameter int                         REPEAT_CYCLES = 2_000_000
) (
   input  logic                Clock,
   input  logic                reset,
   input  logic                rx_valid,
   input  logic [CODE_W-1:0]   rx,
   input  logic                clr,
   output logic [NUM_KEYS-1:0] pressed,
   output logic [NUM_KEYS-1:0] held,
   output logic                unknown
);

   localparam int KEY_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

   kbd_state_t          state_q, state_d;
   logic [NUM_KEYS-1:0] hit;
   logic                is_break;
   logic [NUM_KEYS-1:0] make_vec;
   logic [NUM_KEYS-1:0] brk_vec;
   logic [NUM_KEYS-1:0] rep_set;
   logic                unknown_d;

   kbd_code_match #(
      .NUM_KEYS   (NUM_KEYS),
      .CODE_W     (CODE_W),
      .KEY_CODES  (KEY_CODES),
      .BREAK_CODE (BREAK_CODE)
   ) u_match (
      .rx       (rx),
      .hit      (hit),
      .is_break (is_break)
   );

   // Next state and per-byte events; nothing moves without rx_valid.
   always_comb begin
      state_d   = state_q;
      make_vec  = '0;
      brk_vec   = '0;
      unknown_d = 1'b0;
      if (rx_valid) begin
         unique case (state_q)
            IDLE: begin
               if (is_break) begin
                  state_d = BRK;
               end else if (hit != '0) begin
                  make_vec = hit;
               end else begin
                  unknown_d = 1'b1;
               end
            end
            BRK: begin
               brk_vec = hit;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clock) begin
      if (reset) begin
         state_q <= IDLE;
         pressed <= '0;
         held    <= '0;
         unknown <= 1'b0;
      end else begin
         state_q <= state_d;
         // Sets are OR-ed in after the clear so a same-cycle set wins.
         pressed <= (pressed & ~{NUM_KEYS{clr}}) | make_vec | rep_set;
         held    <= (held | make_vec) & ~brk_vec;
         unknown <= unknown_d;
      end
   end

   generate
      if (REPEAT_EN) begin : g_repeat
         localparam int CNT_W = $clog2(REPEAT_CYCLES);

         logic [CNT_W-1:0] cnt_q;
         logic [KEY_W-1:0] last_key;
         logic [KEY_W-1:0] make_idx;
         logic             fire;

         // Lowest matching index becomes the repeat target on a make.
         always_comb begin
            make_idx = '0;
            for (int i = NUM_KEYS - 1; i >= 0; i--) begin
               if (make_vec[i]) make_idx = KEY_W'(i);
            end
         end

         assign fire = held[last_key] && (cnt_q == CNT_W'(REPEAT_CYCLES - 1));

         always_comb begin
            rep_set = '0;
            if (fire) rep_set[last_key] = 1'b1;
         end

         always_ff @(posedge Clock) begin
            if (reset) begin
               cnt_q    <= '0;
               last_key <= '0;
            end else if (make_vec != '0) begin
               cnt_q    <= '0;
               last_key <= make_idx;
            end else if (!held[last_key] || fire) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
      end else begin : g_no_repeat
         assign rep_set = '0;
      end
   endgenerate

endmodule

// File: tb/tb_kbd_keymap_decoder.sv
// Directed self-checking bench for kbd_keymap_decoder, run with an 8-cycle
// auto-repeat period so repeat behaviour is observable.
module tb_kbd_keymap_decoder;

   logic       Clock = 1'b0;
   logic       reset = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx = '0;
   logic       clr = 1'b0;
   logic [4:0] pressed;
   logic [4:0] held;
   logic       unknown;

   int n_checks = 0;
   int n_bad    = 0;

   kbd_keymap_decoder #(
      .REPEAT_CYCLES (8)
   ) dut (
      .Clock    (Clock),
      .reset    (reset),
      .rx_valid (rx_valid),
      .rx       (rx),
      .clr      (clr),
      .pressed  (pressed),
      .held     (held),
      .unknown  (unknown)
   );

   always #5 Clock = ~Clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic send(input logic [7:0] code);
      rx       = code;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   initial begin
      #1;
      // Reset state and a single make followed by consume.
      do_reset();
      check("rst_pressed", pressed, 5'b00000);
      check("rst_held", held, 5'b00000);
      check("rst_unknown", unknown, 1'b0);
      send(8'd13);
      check("enter_pressed", pressed, 5'b00001);
      check("enter_held", held, 5'b00001);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_pressed", pressed, 5'b00000);
      check("clr_held", held, 5'b00001);

      // Make, break prefix, release, then FSM back in IDLE.
      do_reset();
      send(8'd90);
      check("z_make_held", held, 5'b00010);
      send(8'hF0);
      check("z_prefix_held", held, 5'b00010);
      send(8'd90);
      check("z_break_held", held, 5'b00000);
      check("z_break_pressed", pressed, 5'b00010);
      send(8'd58);
      check("x_after_brk_pressed", pressed, 5'b00110);
      check("x_after_brk_held", held, 5'b00100);

      // Unknown code pulses once; break+unknown and double break are silent.
      do_reset();
      send(8'h55);
      check("unk_strobe", unknown, 1'b1);
      check("unk_pressed", pressed, 5'b00000);
      check("unk_held", held, 5'b00000);
      tick();
      check("unk_one_cycle", unknown, 1'b0);
      send(8'hF0);
      check("brk_no_unk", unknown, 1'b0);
      send(8'h55);
      check("brk_unk_silent", unknown, 1'b0);
      check("brk_unk_pressed", pressed, 5'b00000);
      send(8'hF0);
      send(8'hF0);
      check("dbl_brk_no_unk", unknown, 1'b0);
      send(8'd13);
      check("dbl_brk_then_make", pressed, 5'b00001);

      // clr in the same cycle as a make: the new set wins, others clear.
      do_reset();
      send(8'd13);
      send(8'd90);
      check("pre_clr_pressed", pressed, 5'b00011);
      rx       = 8'd37;
      rx_valid = 1'b1;
      clr      = 1'b1;
      tick();
      rx_valid = 1'b0;
      clr      = 1'b0;
      check("clr_make_pressed", pressed, 5'b01000);
      check("clr_make_held", held, 5'b01011);

      // Auto-repeat on RIGHT: re-asserts at +8, +16, +24, silent after release.
      do_reset();
      send(8'd39);
      check("rep_make", pressed, 5'b10000);
      clr = 1'b1;
      for (int k = 1; k <= 50; k++) begin
         logic exp_bit;
         rx_valid = (k == 29) || (k == 30);
         rx       = (k == 29) ? 8'hF0 : 8'd39;
         tick();
         rx_valid = 1'b0;
         exp_bit  = (k == 8) || (k == 16) || (k == 24);
         check($sformatf("rep_k%0d", k), pressed[4], exp_bit);
         clr = exp_bit;
      end
      clr = 1'b0;
      check("rep_released_held", held, 5'b00000);

      // Back-to-back codes every cycle, then reset in the middle of a break.
      do_reset();
      rx_valid = 1'b1;
      rx = 8'd13; tick();
      rx = 8'd90; tick();
      rx = 8'd58; tick();
      rx = 8'd37; tick();
      rx = 8'd39; tick();
      rx_valid = 1'b0;
      check("b2b_pressed", pressed, 5'b11111);
      check("b2b_held", held, 5'b11111);
      check("b2b_unknown", unknown, 1'b0);
      send(8'hF0);
      do_reset();
      check("midbrk_rst_pressed", pressed, 5'b00000);
      check("midbrk_rst_held", held, 5'b00000);
      send(8'd13);
      check("post_rst_make_pressed", pressed, 5'b00001);
      check("post_rst_make_held", held, 5'b00001);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule

// File: doc/kbd_keymap_decoder.md
# kbd_keymap_decoder

Parametrised keyboard scan-code decoder that turns a stream of received code bytes into per-key held levels and sticky press flags for the game loop. It generalises the fixed five-key controller: the key table, count and code width are parameters; it adds make/break (release) tracking, a byte-valid handshake, clear-on-consume and optional auto-repeat. It sits between the serial/UART receiver and the game loop.

## Interface

**Parameters**
- `NUM_KEYS`, 5: number of decoded keys/channels.
- `CODE_W`, 8: scan-code width.
- `KEY_CODES`, {8'd39, 8'd37, 8'd58, 8'd90, 8'd13}: packed `NUM_KEYS*CODE_W` table. Key i is `KEY_CODES[i*CODE_W +: CODE_W]`, so index 0 Enter(13), 1 Z(90), 2 X(58), 3 Left(37), 4 Right(39).
- `BREAK_CODE`, 8'hF0: prefix marking the next code as a release.
- `REPEAT_EN`, 1: enables auto-repeat.
- `REPEAT_CYCLES`, 2_000_000: hold time before each auto-repeat re-assert, minimum 2.

**Ports**
- `Clock` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `rx_valid` in 1: `rx` holds a new code this cycle; a one-cycle strobe per byte.
- `rx` in CODE_W: received code; sampled only when `rx_valid`=1.
- `clr` in 1: game loop has consumed events; clears `pressed`.
- `pressed` out NUM_KEYS: sticky press flags, one per key.
- `held` out NUM_KEYS: current key-down level, one per key.
- `unknown` out 1: one-cycle strobe for an unmatched, non-break code.

## Operation

**Reset**
- `pressed`, `held` and `unknown` are 0.
- FSM is in IDLE; repeat counter and `last_key` are 0.

**FSM** (2 states; advances only on `rx_valid`)
- IDLE + `rx`==BREAK_CODE -> BRK. No flag change.
- IDLE + `rx` matches key i (make):
  - `held[i]`<=1 and `pressed[i]`<=1.
  - `last_key`<=i; repeat counter<=0.
- IDLE + no match: `unknown`<=1 for one cycle; stay in IDLE.
- BRK + `rx` matches key i: `held[i]`<=0. Go to IDLE.
- BRK + no match (including a second BREAK_CODE): go to IDLE; no flags change; no `unknown`.

**Matching**
- Parallel compare against all table entries.
- Duplicate table entries: every matching bit is affected.
- If a code equals BREAK_CODE, the break interpretation wins.

**Sticky flags**
- `pressed[i]` stays 1 until `clr`.
- If `clr` and a set of bit i occur in the same cycle, the set wins. Other bits clear.

**Auto-repeat** (REPEAT_EN=1)
- One shared counter tracks `last_key`.
- While `held[last_key]`=1, the counter increments each cycle.
- On reaching REPEAT_CYCLES-1:
  - `pressed[last_key]`<=1; counter<=0.
- While `held[last_key]`=0, the counter is held at 0.
- A new make on another key retargets `last_key` and restarts the count.
- With REPEAT_EN=0, the counter logic is removed.

**Other rules**
- Make on an already-held key behaves as a normal make: re-sets `pressed` and restarts repeat (typematic from keyboard).
- `reset` overrides everything, including mid-BRK.

## Timing
- All outputs are registered.
- `pressed`/`held` update on the edge after the `rx_valid` cycle (1-cycle latency).
- `unknown` is high exactly the cycle after the unmatched byte.
- `clr` takes effect on the next edge.
- A make followed immediately by `clr` one cycle later: the flag is visible for at least one cycle.
- Back-to-back `rx_valid` every cycle is supported; no backpressure and no byte dropped.
- First auto-repeat re-assert occurs REPEAT_CYCLES cycles after the make update, then every REPEAT_CYCLES.

## Structure
- Shared package `kbd_pkg`:
  - default scan-code constants (ENTER=13, KEY_Z=90, KEY_X=58, LEFT=37, RIGHT=39, BREAK=8'hF0);
  - FSM state enum {IDLE, BRK};
  - default `KEY_CODES` localparam.
- One natural sub-module: `kbd_code_match` (combinational compare of `rx` against the table -> `NUM_KEYS`-bit hit vector plus `is_break`).
- Repeat counter stays inline; width is $clog2(REPEAT_CYCLES).

## Test plan
- Reset, then `rx`=13 with `rx_valid` -> next cycle `pressed`=5'b00001 and `held`=5'b00001; `clr` -> `pressed`=0 while `held` stays 1.
- Bytes 8'hF0 then 90 after a make of 90 -> `held[1]` goes 1 then 0, `pressed[1]` stays 1; FSM back in IDLE (next 58 sets bit 2).
- `rx`=8'h55 -> `unknown` pulses one cycle, no flags change; 8'hF0 then 8'h55 -> no `unknown`, no change.
- `clr` in the same cycle as the make of 37 -> `pressed[3]`=1 after the edge; other previously set bits clear.
- REPEAT_CYCLES=8, hold 39 for 30 cycles with `clr` each time a flag is seen -> `pressed[4]` re-asserts at +8, +16 and +24 cycles; after the break, no further re-asserts.
- Back-to-back codes 13, 90, 58, 37, 39 on consecutive cycles -> `pressed`=5'b11111 and `held`=5'b11111; `reset` asserted after 8'hF0 -> all 0 and the next 13 is treated as a make.
